// File: rtl/conv_column_feeder.sv
// Line-buffer front end for the 3x3 systolic convolution array.
// Turns a raster pixel stream into packed vertical columns {row y-2, row y-1, row y}.
module conv_column_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic                    load_weight,
  output logic [3*DATA_WIDTH-1:0] input_col,
  output logic                    col_valid,
  output logic                    window_valid,
  output logic                    frame_done
);

  // state    | meaning
  // S_IDLE   | waiting for start, counters held at zero
  // S_LOAD   | one-cycle load_weight strobe to the array
  // S_FILL   | rows 0 and 1 written into the line buffers, no columns
  // S_STREAM | every accept emits a column one cycle later
  // S_DONE   | one-cycle frame_done, last column visible
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FILL, S_STREAM, S_DONE} state_t;

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [XW-1:0]             r_x;
  logic [YW-1:0]             r_y;
  logic [DATA_WIDTH-1:0]     r_lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]     r_lb1 [IMG_WIDTH];
  logic [3*DATA_WIDTH-1:0]   r_col;
  logic                      r_col_valid;
  logic                      r_window_valid;
  logic                      w_accept;
  logic                      w_last_x;

  assign w_last_x = (r_x == X_LAST);
  assign w_accept = pix_valid && pix_ready;

  always_comb begin
    w_state_nxt = r_state;
    pix_ready   = 1'b0;
    load_weight = 1'b0;
    frame_done  = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        load_weight = 1'b1;
        w_state_nxt = S_FILL;
      end
      S_FILL: begin
        pix_ready = 1'b1;
        if (pix_valid && w_last_x && (r_y == YW'(1))) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        pix_ready = 1'b1;
        if (pix_valid && w_last_x && (r_y == Y_LAST)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        frame_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state == S_IDLE)) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      if (w_last_x) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // Buffers are never cleared: FILL overwrites both rows before any column reads them.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_lb1[r_x] <= r_lb0[r_x];
      r_lb0[r_x] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col          <= '0;
      r_col_valid    <= 1'b0;
      r_window_valid <= 1'b0;
    end else begin
      r_col_valid    <= 1'b0;
      r_window_valid <= 1'b0;
      if (w_accept && (r_state == S_STREAM)) begin
        r_col          <= {r_lb1[r_x], r_lb0[r_x], pix_in};
        r_col_valid    <= 1'b1;
        r_window_valid <= (r_x >= XW'(2));
      end
    end
  end

  assign input_col    = r_col;
  assign col_valid    = r_col_valid;
  assign window_valid = r_window_valid;

endmodule

// File: tb/tb_conv_column_feeder.sv
// Scoreboard bench for conv_column_feeder: a 4x4 instance for the directed/random
// frames and a default 28x28 instance for the full-size frame.
module tb_conv_column_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        pix_valid;
  logic [7:0]  pix_in;
  logic        cur;

  logic        s_ready, s_load, s_colv, s_winv, s_done;
  logic [23:0] s_col;
  logic        l_ready, l_load, l_colv, l_winv, l_done;
  logic [23:0] l_col;

  always #5 clk = ~clk;

  conv_column_feeder #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_s (
    .clk(clk), .rst(rst), .start(start && !cur), .pix_in(pix_in),
    .pix_valid(pix_valid && !cur), .pix_ready(s_ready), .load_weight(s_load),
    .input_col(s_col), .col_valid(s_colv), .window_valid(s_winv), .frame_done(s_done));

  conv_column_feeder dut_l (
    .clk(clk), .rst(rst), .start(start && cur), .pix_in(pix_in),
    .pix_valid(pix_valid && cur), .pix_ready(l_ready), .load_weight(l_load),
    .input_col(l_col), .col_valid(l_colv), .window_valid(l_winv), .frame_done(l_done));

  wire        m_ready = cur ? l_ready : s_ready;
  wire        m_load  = cur ? l_load  : s_load;
  wire        m_colv  = cur ? l_colv  : s_colv;
  wire        m_winv  = cur ? l_winv  : s_winv;
  wire        m_done  = cur ? l_done  : s_done;
  wire [23:0] m_col   = cur ? l_col   : s_col;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint expv);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  logic [23:0] q_col[$];
  bit          q_win[$];
  logic [7:0]  pix_hist [0:783];
  int          n_acc = 0;
  int          ph = 0;          // 0 idle, 1 load, 2 accepting, 3 done
  bit          exp_colv = 0;
  bit          after_rst = 0;
  int          cnt_col = 0;
  int          cnt_win = 0;

  always @(negedge clk) begin
    int w, h, k;
    bit acc;
    logic [23:0] ec;
    bit ew;
    w = cur ? 28 : 4;
    h = cur ? 28 : 4;

    chk(m_colv == exp_colv, "col_valid_timing", m_colv, exp_colv);
    if (m_colv) begin
      if (q_col.size() == 0) begin
        chk(1'b0, "unexpected_column", m_col, 0);
      end else begin
        ec = q_col.pop_front();
        ew = q_win.pop_front();
        chk(m_col == ec, "input_col", m_col, ec);
        chk(m_winv == ew, "window_valid", m_winv, ew);
      end
      cnt_col++;
      if (m_winv) cnt_win++;
    end
    chk(m_load == (ph == 1), "load_weight", m_load, ph == 1);
    chk(m_ready == (ph == 2), "pix_ready", m_ready, ph == 2);
    chk(m_done == (ph == 3), "frame_done", m_done, ph == 3);
    if (after_rst) begin
      chk(m_col == 24'h0, "reset_input_col", m_col, 0);
      chk(m_winv == 1'b0, "reset_window_valid", m_winv, 0);
    end
    if (ph == 3) begin
      chk(cnt_col == (h - 2) * w, "col_total", cnt_col, (h - 2) * w);
      chk(cnt_win == (h - 2) * (w - 2), "win_total", cnt_win, (h - 2) * (w - 2));
      cnt_col = 0;
      cnt_win = 0;
    end

    // predict the next cycle from the inputs about to be sampled
    acc = pix_valid && m_ready && !rst;
    exp_colv = 1'b0;
    if (acc) begin
      k = n_acc;
      pix_hist[k] = pix_in;
      if (k / w >= 2) begin
        q_col.push_back({pix_hist[k - 2 * w], pix_hist[k - w], pix_in});
        q_win.push_back((k % w) >= 2);
        exp_colv = 1'b1;
      end
      n_acc = (k == w * h - 1) ? 0 : k + 1;
    end
    if (rst) begin
      ph = 0;
      n_acc = 0;
      q_col.delete();
      q_win.delete();
      cnt_col = 0;
      cnt_win = 0;
      exp_colv = 1'b0;
    end else begin
      case (ph)
        0: ph = start ? 1 : 0;
        1: ph = 2;
        2: ph = (acc && n_acc == 0) ? 3 : 2;
        default: ph = 0;
      endcase
    end
    after_rst = rst;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix_val(input int mode, input int i, input int w);
    case (mode)
      0:       return 8'(i + 1);
      1:       return 8'(101 + i);
      default: return 8'((i / w + i % w) % 256);
    endcase
  endfunction

  // abort_at: assert rst once that many pixels are accepted (-1 = never)
  // start_at: raise start while offering that pixel index (-1 = never)
  task automatic frame(input int mode, input bit gaps, input int abort_at, input int start_at);
    int w, h, i, budget;
    bit accepted;
    w = cur ? 28 : 4;
    h = cur ? 28 : 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    i = 0;
    budget = 0;
    while (i < w * h) begin
      pix_valid = gaps ? ($urandom_range(99) >= 50) : 1'b1;
      pix_in    = pix_val(mode, i, w);
      start     = (i == start_at);
      accepted  = pix_valid && m_ready;
      tick();
      if (accepted) i++;
      if (accepted && i == abort_at) begin
        pix_valid = 1'b0;
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        return;
      end
      budget++;
      if (budget > 20000) begin
        $display("FAIL frame_timeout: got %0d pixels, expected %0d", i, w * h);
        $fatal(1, "frame did not complete");
      end
    end
    pix_valid = 1'b0;
    start = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pix_valid = 1'b0;
    pix_in = '0;
    cur = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    // pixels are offered from the LOAD cycle onward; only the ready ones may land
    frame(0, 1'b0, -1, -1);
    frame(0, 1'b1, -1, -1);
    repeat (2) tick();
    frame(0, 1'b0, 10, 9);
    start = 1'b1;
    rst = 1'b1;
    tick();
    start = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    frame(0, 1'b0, -1, -1);
    frame(1, 1'b0, -1, -1);
    frame(0, 1'b1, -1, 12);
    repeat (2) tick();
    cur = 1'b1;
    tick();
    frame(2, 1'b0, -1, -1);
    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
